ecg_sample_packer: RTL and testbench
====================================

# ecg_sample_packer

- Write-domain stage that sits directly upstream of the team's asynchronous block FIFO and runs on its write clock.
- Accepts one wide ECG sample per `sample_valid` pulse from the front-end acquisition logic.
- Splits each sample into MSB-first bytes, optionally preceded by a sequence header byte, and pushes them into the FIFO write port (`winc`/`wdata`) under `wfull` backpressure.
- Samples that arrive while a previous sample is still being drained are dropped and counted.

## Interface
Reset is `wrst_n`: asynchronous, active-low. The clock is `wclk`.

Parameters:
- `SWIDTH`, 24: sample width in bits. Must be a multiple of 8 and at least 8.
- `DSIZE`, 8: byte width. Must equal the FIFO `DSIZE`.
- `CNTW`, 8: width of the drop counter.

Ports:
- `wclk`  in  1  write-domain clock
- `wrst_n`  in  1  asynchronous active-low reset
- `sample_valid`  in  1  one-cycle strobe: `sample_data` is valid
- `sample_data`  in  SWIDTH  sample, two's complement, passed through unmodified
- `wfull`  in  1  FIFO full flag, registered in `wclk` domain
- `clr_stats`  in  1  synchronous clear of `drop_cnt` and `overflow`
- `winc`  out  1  FIFO write request
- `wdata`  out  DSIZE  FIFO write data
- `busy`  out  1  a sample is held and not yet fully written
- `drop_cnt`  out  CNTW  saturating count of dropped samples
- `overflow`  out  1  sticky: at least one sample dropped

## Operation
- **Constants:** `NB = SWIDTH/8` data bytes per sample. A byte is accepted on every `wclk` edge where `winc=1` and `wfull=0`.
- **IDLE:**
  - `sample_valid=1` loads the holding register and sets `busy`.
  - If the header is compiled in, go to HDR. Otherwise go to DATA with byte index `idx=NB-1`.
- **HDR:**
  - `wdata = {4'hA, seq[3:0]}`.
  - On acceptance, go to DATA with `idx=NB-1`.
- **DATA:**
  - `wdata = hold[8*idx +: 8]`.
  - On acceptance, if `idx>0`, decrement `idx`.
  - On acceptance, if `idx=0` (last byte), go to IDLE.
  - Exception: if `sample_valid=1` on that same edge, load the new sample and go directly to HDR or DATA. This back-to-back case is not a drop.
- **Write request:** `winc = (state!=IDLE) & ~wfull`. It is combinational, so the packer never issues a write while full. `wdata` holds stable while `wfull=1`.
- **Drops:** `sample_valid=1` while `busy` is a drop, except the last-byte-accept case above.
  - The dropped sample is discarded and the held sample is unaffected.
  - `drop_cnt` increments, saturating at 2^CNTW-1. `overflow` is set.
- **`clr_stats`:** zeroes `drop_cnt` and `overflow`. If a drop occurs on the same cycle, the clear wins and the drop is not counted.
- **`seq`:** 4 bits, incremented on each accepted (loaded) sample, wraps 15→0. The header carries the `seq` value of the sample it precedes.
- **Reset:**
  - Outputs: `winc=0`, `wdata=0`, `busy=0`, `drop_cnt=0`, `overflow=0`.
  - Internal: state IDLE, `seq=0`, hold register 0.
  - Reset asserted mid-sample abandons the partial sample. The bytes already written stay in the FIFO; FIFO-side recovery is the consumer's job.

## Timing
- **Latency:** `sample_valid` at edge N → `winc=1` for the first byte from after edge N, accepted at edge N+1 if `wfull=0`.
- **Throughput:** one byte per cycle when not full. A full sample takes NB+1 cycles with the header, NB without.
- **Max sustainable sample rate:** one sample per NB+1 (or NB) cycles. Faster arrivals drop.
- **`wfull` stall:** extends the current byte by exactly the number of cycles `wfull=1`. There is no byte loss and no duplicate.
- **`busy`:** rises the cycle after a load. It falls the cycle after the last byte is accepted, unless a back-to-back load occurred.

## Configuration
- **`PACKER_SEQ_HDR_EN` defined:** HDR state, `seq` counter and header byte present. NB+1 bytes per sample.
- **`PACKER_SEQ_HDR_EN` undefined:** no HDR state and no `seq` register. NB bytes per sample; IDLE goes straight to DATA. All other behaviour is identical.

## Structure
- **Shared package `ecg_pkg`:** state encoding (IDLE, HDR, DATA), header nibble constant `HDR_MAGIC=4'hA`, default `SWIDTH`.
- **Sub-module `sat_counter`:** parameterized width, with increment, synchronous clear and saturation. It is reused for `drop_cnt`.
- **Top level:** remaining FSM, holding register and byte mux live in `ecg_sample_packer`.

## Test plan
Default parameters, header enabled, FIFO model `wfull=0` unless stated.
- **Single sample:** `sample_data=24'h123456` → bytes A0, 12, 34, 56 on 4 consecutive edges. `busy` then falls and `seq=1`.
- **Back-to-back:** second sample pulsed on the edge the first sample's last byte is accepted → header A1 follows immediately, `drop_cnt=0`.
- **Stall:** hold `wfull=1` for 5 cycles during byte 34 → `winc=0` throughout and `wdata` stays 34. The byte sequence is unchanged afterwards.
- **Drop:** `sample_valid` 2 cycles after a load → `drop_cnt=1`, `overflow=1`, held sample is output intact. A following `clr_stats` returns both to 0.
- **Saturation and wrap:** 300 drops → `drop_cnt=255`. 17 accepted samples → 17th header A0.
- **Reset mid-sample:** reset after byte 12 → all outputs 0, IDLE. The next sample starts with header A0.

Source files
------------

// File: rtl/ecg_pkg.sv
`default_nettype none
// ecg_pkg: shared packer state encoding, header magic nibble and default sample width.
package ecg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [3:0] HDR_MAGIC  = 4'hA;
  localparam int         SWIDTH_DEF = 24;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// sat_counter: up-counter that sticks at all-ones; synchronous clear takes priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/ecg_sample_packer.sv
`default_nettype none
// ecg_sample_packer: splits each ECG sample into MSB-first bytes for the async FIFO write port.
// Define PACKER_SEQ_HDR_EN to prefix every sample with a {HDR_MAGIC, seq} header byte.
module ecg_sample_packer
  import ecg_pkg::*;
#(
  parameter int SWIDTH = SWIDTH_DEF,
  parameter int DSIZE  = 8,
  parameter int CNTW   = 8
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic              sample_valid,
  input  logic [SWIDTH-1:0] sample_data,
  input  logic              wfull,
  input  logic              clr_stats,
  output logic              winc,
  output logic [DSIZE-1:0]  wdata,
  output logic              busy,
  output logic [CNTW-1:0]   drop_cnt,
  output logic              overflow
);

  localparam int NB = SWIDTH / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

`ifdef PACKER_SEQ_HDR_EN
  localparam state_t LOAD_ST = ST_HDR;
`else
  localparam state_t LOAD_ST = ST_DATA;
`endif

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [SWIDTH-1:0] hold_q;
  logic              overflow_q;
  logic              accept, last_acc, load, drop;
  logic [7:0]        byte_w;

  assign winc     = (state_q != ST_IDLE) & ~wfull;
  assign accept   = winc;
  assign last_acc = accept & (state_q == ST_DATA) & (idx_q == '0);
  // A sample arriving on the final byte's accept edge is a back-to-back load, not a drop.
  assign load     = sample_valid & ((state_q == ST_IDLE) | last_acc);
  assign drop     = sample_valid & ~load;
  assign busy     = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = LOAD_ST;
          idx_d   = IW'(NB - 1);
        end
      end
      ST_HDR: begin
        if (accept) begin
          state_d = ST_DATA;
          idx_d   = IW'(NB - 1);
        end
      end
      ST_DATA: begin
        if (accept) begin
          if (idx_q != '0) begin
            idx_d = idx_q - IW'(1);
          end else if (load) begin
            state_d = LOAD_ST;
            idx_d   = IW'(NB - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) begin
        hold_q <= sample_data;
      end
    end
  end

`ifdef PACKER_SEQ_HDR_EN
  logic [3:0] seq_q;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      seq_q <= '0;
    end else if (load) begin
      seq_q <= seq_q + 4'd1;
    end
  end
`endif

  // seq has already advanced at load time, so the header carries seq-1.
  always_comb begin
    byte_w = 8'h00;
    case (state_q)
`ifdef PACKER_SEQ_HDR_EN
      ST_HDR:  byte_w = {HDR_MAGIC, seq_q - 4'd1};
`endif
      ST_DATA: byte_w = hold_q[8*idx_q +: 8];
      default: byte_w = 8'h00;
    endcase
  end

  assign wdata = DSIZE'(byte_w);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      overflow_q <= 1'b0;
    end else if (clr_stats) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;

  sat_counter #(
    .W(CNTW)
  ) u_drop_cnt (
    .clk_i  (wclk),
    .rst_ni (wrst_n),
    .clr_i  (clr_stats),
    .inc_i  (drop),
    .cnt_o  (drop_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_ecg_sample_packer.sv
`default_nettype none
// tb_ecg_sample_packer: queue-model check of ecg_sample_packer plus hand-computed byte streams.
// Follows PACKER_SEQ_HDR_EN the same way the design does.
module tb_ecg_sample_packer;

  localparam int SWIDTH = 24;
  localparam int DSIZE  = 8;
  localparam int CNTW   = 8;
  localparam int NB     = SWIDTH / 8;
`ifdef PACKER_SEQ_HDR_EN
  localparam int HB = 1;
`else
  localparam int HB = 0;
`endif
  localparam int BPS = NB + HB;

  logic              wclk = 1'b0;
  logic              wrst_n = 1'b0;
  logic              sample_valid = 1'b0;
  logic [SWIDTH-1:0] sample_data = '0;
  logic              wfull = 1'b0;
  logic              clr_stats = 1'b0;
  logic              winc;
  logic [DSIZE-1:0]  wdata;
  logic              busy;
  logic [CNTW-1:0]   drop_cnt;
  logic              overflow;

  ecg_sample_packer #(
    .SWIDTH(SWIDTH), .DSIZE(DSIZE), .CNTW(CNTW)
  ) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .wfull        (wfull),
    .clr_stats    (clr_stats),
    .winc         (winc),
    .wdata        (wdata),
    .busy         (busy),
    .drop_cnt     (drop_cnt),
    .overflow     (overflow)
  );

  always #5 wclk = ~wclk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Model: the bytes still owed for the held sample, in output order.
  logic [7:0] m_q[$];
  int         m_seq = 0;
  int         m_cnt = 0;
  bit         m_ovf = 1'b0;

  always @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      m_q.delete();
      m_seq = 0;
      m_cnt = 0;
      m_ovf = 1'b0;
    end else begin
      bit was_idle, acc, last;
      was_idle = (m_q.size() == 0);
      acc      = !was_idle && !wfull;
      last     = acc && (m_q.size() == 1);
      if (acc) void'(m_q.pop_front());
      if (sample_valid) begin
        if (was_idle || last) begin
          if (HB == 1) m_q.push_back(8'hA0 | 8'(m_seq % 16));
          for (int i = NB - 1; i >= 0; i--) m_q.push_back(sample_data[8*i +: 8]);
          m_seq = (m_seq + 1) % 16;
        end else if (!clr_stats) begin
          if (m_cnt < (2**CNTW) - 1) m_cnt++;
          m_ovf = 1'b1;
        end
      end
      if (clr_stats) begin
        m_cnt = 0;
        m_ovf = 1'b0;
      end
    end
  end

  always @(negedge wclk) begin
    chk("busy", 32'(busy), 32'(m_q.size() != 0));
    chk("winc", 32'(winc), 32'((m_q.size() != 0) && !wfull));
    if (m_q.size() != 0) chk("wdata", 32'(wdata), 32'(m_q[0]));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  end

  // Log of bytes actually accepted by the FIFO, for the literal stream checks.
  logic [7:0] log_q[$];
  logic [7:0] exp_q[$];

  always @(posedge wclk) begin
    if (wrst_n && winc && !wfull) log_q.push_back(wdata[7:0]);
  end

  function automatic void ex(logic [7:0] b);
    exp_q.push_back(b);
  endfunction

  function automatic void check_log(string name);
    chk({name, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk(name, 32'(log_q[i]), 32'(exp_q[i]));
    log_q.delete();
    exp_q.delete();
  endfunction

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge wclk);
      #2;
    end
  endtask

  task automatic pulse(logic [SWIDTH-1:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    tick();
    sample_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_winc", 32'(winc), 0);
    chk("rst_wdata", 32'(wdata), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    chk("rst_overflow", 32'(overflow), 0);
    wrst_n = 1'b1;
    tick(2);

    // Single sample
    pulse(24'h123456);
    tick(BPS + 2);
`ifdef PACKER_SEQ_HDR_EN
    ex(8'hA0);
`endif
    ex(8'h12); ex(8'h34); ex(8'h56);
    check_log("single");
    chk("single_busy", 32'(busy), 0);

    // Back-to-back: second strobe lands on the first sample's last accept edge
    pulse(24'hABCDEF);
    tick(BPS - 1);
    pulse(24'h654321);
    tick(BPS + 2);
`ifdef PACKER_SEQ_HDR_EN
    ex(8'hA1);
`endif
    ex(8'hAB); ex(8'hCD); ex(8'hEF);
`ifdef PACKER_SEQ_HDR_EN
    ex(8'hA2);
`endif
    ex(8'h65); ex(8'h43); ex(8'h21);
    check_log("b2b");
    chk("b2b_drop_cnt", 32'(drop_cnt), 0);

    // Stall on byte 34
    pulse(24'h123456);
    tick(HB + 1);
    wfull = 1'b1;
    tick(2);
    chk("stall_winc", 32'(winc), 0);
    chk("stall_wdata", 32'(wdata), 32'h34);
    tick(3);
    wfull = 1'b0;
    tick(BPS + 2);
`ifdef PACKER_SEQ_HDR_EN
    ex(8'hA3);
`endif
    ex(8'h12); ex(8'h34); ex(8'h56);
    check_log("stall");

    // Drop two cycles after a load, then clear
    pulse(24'h0A0B0C);
    tick(1);
    pulse(24'hFFFFFF);
    chk("drop_cnt1", 32'(drop_cnt), 1);
    chk("drop_ovf1", 32'(overflow), 1);
    tick(BPS + 2);
`ifdef PACKER_SEQ_HDR_EN
    ex(8'hA4);
`endif
    ex(8'h0A); ex(8'h0B); ex(8'h0C);
    check_log("drop");
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("clr_cnt", 32'(drop_cnt), 0);
    chk("clr_ovf", 32'(overflow), 0);

    // Reset right after byte 12 is accepted
    pulse(24'h123456);
    tick(HB + 1);
    wrst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_winc", 32'(winc), 0);
    chk("mid_rst_wdata", 32'(wdata), 0);
    tick();
    wrst_n = 1'b1;
    tick();
`ifdef PACKER_SEQ_HDR_EN
    ex(8'hA5);
`endif
    ex(8'h12);
    check_log("mid_rst_partial");
    pulse(24'h010203);
    tick(BPS + 2);
`ifdef PACKER_SEQ_HDR_EN
    ex(8'hA0);
`endif
    ex(8'h01); ex(8'h02); ex(8'h03);
    check_log("after_rst");

    // Saturation: hold the FIFO full and strobe 300 times
    wfull = 1'b1;
    pulse(24'h112233);
    sample_valid = 1'b1;
    tick(300);
    sample_valid = 1'b0;
    chk("sat_cnt", 32'(drop_cnt), 255);
    chk("sat_ovf", 32'(overflow), 1);
    wfull = 1'b0;
    tick(BPS + 2);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    log_q.delete();

    // Sequence wrap over 17 samples from reset
    wrst_n = 1'b0;
    tick();
    wrst_n = 1'b1;
    tick();
    for (int k = 0; k < 17; k++) begin
      pulse(SWIDTH'(k));
      tick(BPS + 1);
    end
    chk("wrap_len", 32'(log_q.size()), 32'(17 * BPS));
`ifdef PACKER_SEQ_HDR_EN
    if (log_q.size() == 17 * BPS) begin
      chk("wrap_hdr0", 32'(log_q[0]), 32'hA0);
      chk("wrap_hdr15", 32'(log_q[15 * BPS]), 32'hAF);
      chk("wrap_hdr16", 32'(log_q[16 * BPS]), 32'hA0);
    end
`endif
    log_q.delete();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      sample_valid = ($urandom_range(0, 2) == 0);
      sample_data  = SWIDTH'($urandom);
      wfull        = ($urandom_range(0, 3) == 0);
      clr_stats    = ($urandom_range(0, 60) == 0);
      tick();
    end
    sample_valid = 1'b0;
    wfull        = 1'b0;
    clr_stats    = 1'b0;
    tick(BPS + 3);
    chk("final_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
